// File: rtl/hyperbus_mem_responder.sv
// hyperbus_mem_responder
//   Responder end of the hbus request interface. It answers single-beat read and
//   write requests from an internal 16-bit-wide memory and emulates HyperRAM
//   access timing: a fixed initial latency per operation, doubled when a refresh
//   collision is pending at the moment the request is accepted.
//
// Ports
//   hbus_clk     clock (single clock domain)
//   hbus_rst_n   asynchronous active-low reset
//   hbus_adr_i   request word address (low log2(MEM_DEPTH) bits used, wraps)
//   hbus_dat_i   write data, sampled with hbus_wrq
//   hbus_mask_i  byte mask, sampled with hbus_wrq; 1 = byte not written
//   hbus_rrq     read request pulse
//   hbus_wrq     write request pulse (wins over hbus_rrq)
//   hbus_dat_o   read data, updated only by read responses
//   hbus_ready   one-cycle pulse: write completed
//   hbus_valid   one-cycle pulse: read data valid
//   hbus_busy    high from acceptance through the response cycle
module hyperbus_mem_responder #(
  parameter int HBUS_ADDR_WIDTH  = 32,
  parameter int HBUS_DATA_WIDTH  = 16,
  parameter int MEM_DEPTH        = 1024,
  parameter int RD_LATENCY       = 4,
  parameter int WR_LATENCY       = 4,
  parameter int REFRESH_INTERVAL = 64
) (
  input  logic                         hbus_clk,
  input  logic                         hbus_rst_n,
  input  logic [HBUS_ADDR_WIDTH-1:0]   hbus_adr_i,
  input  logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_i,
  input  logic [HBUS_DATA_WIDTH/8-1:0] hbus_mask_i,
  input  logic                         hbus_rrq,
  input  logic                         hbus_wrq,
  output logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_o,
  output logic                         hbus_ready,
  output logic                         hbus_valid,
  output logic                         hbus_busy
);

  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int MASK_W  = HBUS_DATA_WIDTH / 8;
  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  // Counter must hold the doubled latency minus one.
  localparam int CNT_W   = $clog2(2 * MAX_LAT) + 1;
  localparam int REF_W   = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  localparam logic [CNT_W-1:0] RD_L1 = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] RD_L2 = CNT_W'(2 * RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_L1 = CNT_W'(WR_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_L2 = CNT_W'(2 * WR_LATENCY - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_INTERVAL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LAT  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                     state;
  logic                       op_wr;
  logic [IDX_W-1:0]           idx;
  logic [HBUS_DATA_WIDTH-1:0] wdat;
  logic [MASK_W-1:0]          wmask;
  logic [CNT_W-1:0]           cnt;
  logic [REF_W-1:0]           ref_cnt;
  logic                       ref_pend;
  logic                       accept;
  logic                       commit;
  logic                       unused_adr;

  logic [HBUS_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_comb begin
    accept     = (state == IDLE) && (hbus_rrq || hbus_wrq);
    commit     = (state == LAT) && (cnt == '0) && op_wr;
    unused_adr = ^hbus_adr_i[HBUS_ADDR_WIDTH-1:IDX_W];
  end

  always_ff @(posedge hbus_clk or negedge hbus_rst_n) begin
    if (!hbus_rst_n) begin
      state      <= IDLE;
      op_wr      <= 1'b0;
      idx        <= '0;
      wdat       <= '0;
      wmask      <= '0;
      cnt        <= '0;
      hbus_busy  <= 1'b0;
      hbus_ready <= 1'b0;
      hbus_valid <= 1'b0;
      hbus_dat_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hbus_wrq || hbus_rrq) begin
            op_wr     <= hbus_wrq;
            idx       <= hbus_adr_i[IDX_W-1:0];
            wdat      <= hbus_dat_i;
            wmask     <= hbus_mask_i;
            hbus_busy <= 1'b1;
            if (hbus_wrq) cnt <= ref_pend ? WR_L2 : WR_L1;
            else          cnt <= ref_pend ? RD_L2 : RD_L1;
            state     <= LAT;
          end
        end
        LAT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= RESP;
            if (op_wr) begin
              hbus_ready <= 1'b1;
            end else begin
              hbus_valid <= 1'b1;
              hbus_dat_o <= mem[idx];
            end
          end
        end
        RESP: begin
          hbus_ready <= 1'b0;
          hbus_valid <= 1'b0;
          hbus_busy  <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          hbus_ready <= 1'b0;
          hbus_valid <= 1'b0;
          hbus_busy  <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Refresh emulation: a pending refresh doubles the next accepted request's
  // latency. An acceptance on the same edge as a new refresh consumes the flag,
  // so that refresh is absorbed rather than carried forward.
  always_ff @(posedge hbus_clk or negedge hbus_rst_n) begin
    if (!hbus_rst_n) begin
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
    end else if (REFRESH_INTERVAL > 0) begin
      ref_cnt <= (ref_cnt == REF_LAST) ? '0 : ref_cnt + REF_W'(1);
      if (accept)                    ref_pend <= 1'b0;
      else if (ref_cnt == REF_LAST)  ref_pend <= 1'b1;
    end else begin
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
    end
  end

  // Memory has no reset; commit is gated by the FSM, so a reset mid-write
  // drops the write.
  always_ff @(posedge hbus_clk) begin
    if (commit) begin
      for (int unsigned b = 0; b < MASK_W; b++) begin
        if (!wmask[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

endmodule
